mb_rtu_resp_tx: RTL and testbench
=================================

# mb_rtu_resp_tx

Modbus RTU slave response transmitter that sits directly downstream of the RTU request parser. It accepts a decoded request: function code, start register, register count. It reads register contents from the register file, builds the response frame, appends CRC-16/MODBUS and streams the frame byte by byte into the UART transmitter. It also enforces the 3.5-character inter-frame silence before accepting the next request.

## Interface
- SLAVE_ADDR, 8'h01, address byte placed first in every response
- MAX_REGS, 16'd125, largest legal register count
- GAP_CYCLES, 100000, idle clk cycles after last byte's tx_done before req_ready reasserts
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  one-cycle request strobe; sampled only while req_ready=1
- req_func  in  8  request function code (0x03 read holding, 0x10 write multiple)
- req_reg  in  16  start register address
- req_num  in  16  register count
- req_ready  out  1  high in IDLE only
- reg_rd  out  1  one-cycle register read strobe
- reg_addr  out  16  register address for reg_rd
- reg_data  in  16  register contents, valid exactly 1 cycle after reg_rd
- tx_start  out  1  one-cycle strobe: UART transmits tx_data
- tx_data  out  8  byte to send, held stable until tx_done
- tx_done  in  1  one-cycle strobe from UART: byte finished
- busy  out  1  high from request acceptance through end of gap
- frame_done  out  1  one-cycle pulse on tx_done of final CRC byte

## Operation
- Reset values: req_ready=1, busy=0, reg_rd=0, reg_addr=0, tx_start=0, tx_data=0, frame_done=0, CRC register=16'hFFFF.
- States: IDLE, LOAD, FETCH, WAITD, SEND, WAIT_TX, CRC_LO, CRC_HI, GAP.
- IDLE: on req_valid, latch func/reg/num, CRC←16'hFFFF, go to LOAD.
- LOAD: classify the request.
  - func=0x03, 1≤num≤MAX_REGS → read frame: SLAVE_ADDR, 0x03, byte count (2·num)[7:0], then per register data hi, data lo.
  - func=0x10, 1≤num≤MAX_REGS → echo frame: SLAVE_ADDR, 0x10, reg hi, reg lo, num hi, num lo.
  - Other func → exception code 0x01. Legal func with num=0 or num>MAX_REGS → exception code 0x03.
- FETCH/WAITD: on read frames, before each register's hi byte, pulse reg_rd with reg_addr=req_reg+i (16-bit wrap), capture reg_data next cycle.
- SEND: pulse tx_start with the current byte. Fold that byte into the CRC in the same cycle. Fold order: LSB-first, poly 0xA001, one 8-iteration combinational update per byte.
- WAIT_TX: hold until tx_done, then advance byte index and go to the next header, data or CRC state.
- CRC_LO, CRC_HI: send crc[7:0], then crc[15:8]. The CRC itself is not folded.
- GAP: count GAP_CYCLES, then return to IDLE.
- req_valid outside IDLE is ignored; there is no queueing.
- Byte counter is 9 bits wide: max 3+250 payload bytes.

## Timing
- req_valid to LOAD: 1 cycle. First tx_start occurs 2 cycles after req_valid.
- Read register fetch adds 2 cycles before that register's hi byte.
- Next tx_start is issued no earlier than 1 cycle after the previous tx_done. tx_start is never asserted while waiting on tx_done.
- tx_done outside WAIT_TX is ignored.
- frame_done coincides with the cycle after the final tx_done. busy falls with req_ready rising, GAP_CYCLES cycles later.
- Reset mid-frame: immediate abort, all outputs to reset values, no partial CRC sent.

## Configuration
- MB_RESP_EXCEPTION_EN defined: invalid requests produce the exception frame SLAVE_ADDR, func|0x80, code, CRC lo, CRC hi, followed by the normal GAP.
- Undefined: invalid requests are dropped in LOAD. There is no tx_start and no frame_done, and the block returns to IDLE on the next cycle.

## Test plan
- 0x10 echo: func=0x10, reg=0x0001, num=0x0002 → bytes 01 10 00 01 00 02 10 08, frame_done once, req_ready low for the gap.
- Read: func=0x03, reg=0x0000, num=2, registers 0x1234/0x5678 → 01 03 04 12 34 56 78 + CRC matching model; reg_addr 0x0000 then 0x0001.
- Exception (macro on): func=0x05 → 01 85 01 + CRC (model). num=0 on 0x03 → 01 83 03 + CRC. Macro off: no tx_start.
- UART backpressure: tx_done delayed by random 1–2000 cycles → tx_data stable and exactly one tx_start per byte.
- req_valid during busy plus rst_n pulse mid-data → request ignored, outputs at reset values within the reset cycle, next request yields a correct full frame.
- Address wrap: reg=0xFFFF, num=2 → reg_addr 0xFFFF then 0x0000.

Source files
------------

// File: rtl/mb_rtu_resp_tx.sv
// Modbus RTU slave response transmitter: builds read (0x03) / write-multiple echo (0x10) frames with CRC-16/MODBUS.
// Optional macro MB_RESP_EXCEPTION_EN: invalid requests produce an exception frame instead of being dropped.
module mb_rtu_resp_tx #(
  parameter logic [7:0]  SLAVE_ADDR = 8'h01,
  parameter logic [15:0] MAX_REGS   = 16'd125,
  parameter int unsigned GAP_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [7:0]  req_func,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_num,
  output logic        req_ready,
  output logic        reg_rd,
  output logic [15:0] reg_addr,
  input  logic [15:0] reg_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned IDX_W = 9;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef MB_RESP_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, LOAD, FETCH, WAITD, SEND, WAIT_TX, CRC_LO, CRC_HI, GAP
  } state_t;

  typedef enum logic [1:0] {K_READ, K_ECHO, K_EXC} kind_t;

  state_t             state_q, state_nx;
  kind_t              kind_q, kind_nx, kind_c;
  logic [7:0]         func_q, func_nx;
  logic [15:0]        reg_q, reg_nx;
  logic [15:0]        num_q, num_nx;
  logic [7:0]         code_q, code_nx, code_c;
  logic [15:0]        crc_q, crc_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx, idx_inc;
  logic [IDX_W-1:0]   plen_q, plen_nx, plen_c;
  logic [15:0]        rd_ptr_q, rd_ptr_nx;
  logic [7:0]         data_lo_q, data_lo_nx;
  logic [GAP_W-1:0]   gap_q, gap_nx;
  logic [7:0]         nxt_byte;
  logic               num_ok;
  logic               req_ready_nx, busy_nx, reg_rd_nx, tx_start_nx, frame_done_nx;
  logic [15:0]        reg_addr_nx;
  logic [7:0]         tx_data_nx;

  // One byte of CRC-16/MODBUS, LSB first, reflected poly 0xA001
  function automatic logic [15:0] crc_fold(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign idx_inc = idx_q + IDX_W'(1);

  // Request classification, evaluated while in LOAD
  always_comb begin
    num_ok = (num_q != 16'd0) && (num_q <= MAX_REGS);
    kind_c = K_EXC;
    code_c = 8'h01;
    plen_c = IDX_W'(3);
    if (func_q == 8'h03 || func_q == 8'h10) begin
      code_c = 8'h03;
      if (num_ok) begin
        kind_c = (func_q == 8'h03) ? K_READ : K_ECHO;
        plen_c = (func_q == 8'h03) ? (IDX_W'(3) + {num_q[7:0], 1'b0}) : IDX_W'(6);
      end
    end
  end

  // Header / echo / exception byte at position idx_inc (read data hi bytes come from WAITD)
  always_comb begin
    nxt_byte = SLAVE_ADDR;
    case (kind_q)
      K_READ: begin
        if (idx_inc == IDX_W'(1))      nxt_byte = 8'h03;
        else if (idx_inc == IDX_W'(2)) nxt_byte = {num_q[6:0], 1'b0};
        else                           nxt_byte = data_lo_q;
      end
      K_ECHO: begin
        case (idx_inc)
          IDX_W'(1): nxt_byte = 8'h10;
          IDX_W'(2): nxt_byte = reg_q[15:8];
          IDX_W'(3): nxt_byte = reg_q[7:0];
          IDX_W'(4): nxt_byte = num_q[15:8];
          default:   nxt_byte = num_q[7:0];
        endcase
      end
      default: begin
        nxt_byte = (idx_inc == IDX_W'(1)) ? (func_q | 8'h80) : code_q;
      end
    endcase
  end

  always_comb begin
    state_nx      = state_q;
    kind_nx       = kind_q;
    func_nx       = func_q;
    reg_nx        = reg_q;
    num_nx        = num_q;
    code_nx       = code_q;
    crc_nx        = crc_q;
    idx_nx        = idx_q;
    plen_nx       = plen_q;
    rd_ptr_nx     = rd_ptr_q;
    data_lo_nx    = data_lo_q;
    gap_nx        = gap_q;
    reg_rd_nx     = 1'b0;
    reg_addr_nx   = reg_addr;
    tx_start_nx   = 1'b0;
    tx_data_nx    = tx_data;
    frame_done_nx = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          func_nx   = req_func;
          reg_nx    = req_reg;
          num_nx    = req_num;
          rd_ptr_nx = req_reg;
          crc_nx    = 16'hFFFF;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        kind_nx = kind_c;
        code_nx = code_c;
        plen_nx = plen_c;
        idx_nx  = '0;
        if (kind_c == K_EXC && !EXC_EN) begin
          state_nx = IDLE;
        end else begin
          state_nx    = SEND;
          tx_start_nx = 1'b1;
          tx_data_nx  = SLAVE_ADDR;
        end
      end
      FETCH: begin
        rd_ptr_nx = rd_ptr_q + 16'd1;
        state_nx  = WAITD;
      end
      WAITD: begin
        data_lo_nx  = reg_data[7:0];
        tx_data_nx  = reg_data[15:8];
        tx_start_nx = 1'b1;
        state_nx    = SEND;
      end
      SEND: begin
        crc_nx   = crc_fold(crc_q, tx_data);
        state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          idx_nx = idx_inc;
          if (idx_inc < plen_q) begin
            if (kind_q == K_READ && idx_inc >= IDX_W'(3) && idx_inc[0]) begin
              state_nx    = FETCH;
              reg_rd_nx   = 1'b1;
              reg_addr_nx = rd_ptr_q;
            end else begin
              state_nx    = SEND;
              tx_start_nx = 1'b1;
              tx_data_nx  = nxt_byte;
            end
          end else if (idx_inc == plen_q) begin
            state_nx    = CRC_LO;
            tx_start_nx = 1'b1;
            tx_data_nx  = crc_q[7:0];
          end else if (idx_inc == plen_q + IDX_W'(1)) begin
            state_nx    = CRC_HI;
            tx_start_nx = 1'b1;
            tx_data_nx  = crc_q[15:8];
          end else begin
            state_nx      = GAP;
            frame_done_nx = 1'b1;
            gap_nx        = '0;
          end
        end
      end
      CRC_LO, CRC_HI: begin
        state_nx = WAIT_TX;
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_nx = IDLE;
        else                                 gap_nx   = gap_q + GAP_W'(1);
      end
      default: state_nx = IDLE;
    endcase

    req_ready_nx = (state_nx == IDLE);
    busy_nx      = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kind_q     <= K_READ;
      func_q     <= '0;
      reg_q      <= '0;
      num_q      <= '0;
      code_q     <= '0;
      crc_q      <= 16'hFFFF;
      idx_q      <= '0;
      plen_q     <= '0;
      rd_ptr_q   <= '0;
      data_lo_q  <= '0;
      gap_q      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      reg_rd     <= 1'b0;
      reg_addr   <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_nx;
      kind_q     <= kind_nx;
      func_q     <= func_nx;
      reg_q      <= reg_nx;
      num_q      <= num_nx;
      code_q     <= code_nx;
      crc_q      <= crc_nx;
      idx_q      <= idx_nx;
      plen_q     <= plen_nx;
      rd_ptr_q   <= rd_ptr_nx;
      data_lo_q  <= data_lo_nx;
      gap_q      <= gap_nx;
      req_ready  <= req_ready_nx;
      busy       <= busy_nx;
      reg_rd     <= reg_rd_nx;
      reg_addr   <= reg_addr_nx;
      tx_start   <= tx_start_nx;
      tx_data    <= tx_data_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule

// File: tb/tb_mb_rtu_resp_tx.sv
// Bench for mb_rtu_resp_tx: vector table + scoreboard of expected UART bytes and register addresses.
`timescale 1ns/1ps
module tb_mb_rtu_resp_tx;

  localparam int GAP = 16;
`ifdef MB_RESP_EXCEPTION_EN
  localparam int EXC_LEN = 5;
`else
  localparam int EXC_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_func = '0;
  logic [15:0] req_reg = '0;
  logic [15:0] req_num = '0;
  logic        req_ready;
  logic        reg_rd;
  logic [15:0] reg_addr;
  logic [15:0] reg_data = 16'hDEAD;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        frame_done;

  mb_rtu_resp_tx #(.SLAVE_ADDR(8'h01), .MAX_REGS(16'd125), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_func(req_func),
    .req_reg(req_reg), .req_num(req_num), .req_ready(req_ready), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_data(reg_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  func;
    logic [15:0] rreg;
    logic [15:0] num;
    int          dmax;
    int          exp_len;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] regfile [65536];
  logic [7:0]  exp_q[$];
  logic [15:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rx_count = 0;
  int          fd_count = 0;
  int          uart_dmax = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: accepts a byte on tx_start, returns tx_done after a random delay
  logic [7:0] u_byte;
  bit         u_busy = 0;
  bit         u_bad = 0;
  int         u_cnt = 0;
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      u_busy = 0;
    end else if (u_busy) begin
      if (tx_data !== u_byte) u_bad = 1;
      if (tx_start) u_bad = 1;
      if (u_cnt == 0) begin
        tx_done = 1'b1;
        u_busy  = 0;
        check("tx_hold_single_start", 32'(u_bad), 0);
      end else begin
        u_cnt--;
      end
    end else if (tx_start) begin
      u_byte = tx_data;
      u_busy = 1;
      u_bad  = 0;
      u_cnt  = int'($urandom_range(uart_dmax, 1)) - 1;
      rx_count++;
      check("tx_byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Register file model: data valid in the cycle after reg_rd
  bit          rd_pend = 0;
  logic [15:0] rd_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend  = 0;
      reg_data = 16'hDEAD;
    end else begin
      if (rd_pend) begin
        reg_data = regfile[rd_addr];
        rd_pend  = 0;
      end else begin
        reg_data = 16'hDEAD;
      end
      if (reg_rd) begin
        rd_pend = 1;
        rd_addr = reg_addr;
        check("reg_rd_expected", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) check("reg_addr", 32'(reg_addr), 32'(addr_q.pop_front()));
      end
    end
  end

  always @(negedge clk) if (rst_n && frame_done) fd_count++;

  task automatic push_model(input logic [7:0] f, input logic [15:0] r, input logic [15:0] n,
                            output bit has_frame);
    logic [7:0]  fr[$];
    logic [15:0] crc;
    logic [15:0] v;
    bit          ok;
    ok = (n >= 16'd1) && (n <= 16'd125);
    has_frame = 1;
    if (f == 8'h03 && ok) begin
      fr.push_back(8'h01); fr.push_back(8'h03); fr.push_back(8'(2 * int'(n)));
      for (int i = 0; i < int'(n); i++) begin
        v = regfile[16'(int'(r) + i)];
        addr_q.push_back(16'(int'(r) + i));
        fr.push_back(v[15:8]); fr.push_back(v[7:0]);
      end
    end else if (f == 8'h10 && ok) begin
      fr.push_back(8'h01); fr.push_back(8'h10);
      fr.push_back(r[15:8]); fr.push_back(r[7:0]);
      fr.push_back(n[15:8]); fr.push_back(n[7:0]);
    end else begin
`ifdef MB_RESP_EXCEPTION_EN
      fr.push_back(8'h01); fr.push_back(f | 8'h80);
      fr.push_back((f == 8'h03 || f == 8'h10) ? 8'h03 : 8'h01);
`else
      has_frame = 0;
`endif
    end
    if (has_frame) begin
      crc = 16'hFFFF;
      foreach (fr[k]) begin
        crc = crc ^ {8'h00, fr[k]};
        for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        exp_q.push_back(fr[k]);
      end
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 50000) begin @(negedge clk); t++; end
    check("wait_req_ready", 32'(req_ready), 1);
  endtask

  task automatic do_req(input logic [7:0] f, input logic [15:0] r, input logic [15:0] n,
                        input int dmax, input bit has_frame, input int exp_len, input string tag);
    int rx0, fd0, t, gap_n;
    wait_ready();
    uart_dmax = dmax;
    rx0 = rx_count;
    fd0 = fd_count;
    @(negedge clk);
    req_valid = 1'b1; req_func = f; req_reg = r; req_num = n;
    @(negedge clk);
    req_valid = 1'b0; req_func = 8'h00; req_reg = 16'h0; req_num = 16'h0;
    check({tag, "_load_busy_ready_start"}, {29'd0, busy, req_ready, tx_start}, 32'b100);
    @(negedge clk);
    if (has_frame) begin
      check({tag, "_first_tx_start"}, 32'(tx_start), 1);
      t = 0;
      while (!frame_done && t < 40000) begin @(negedge clk); t++; end
      check({tag, "_frame_done"}, 32'(frame_done), 1);
      gap_n = 0;
      while (!req_ready && gap_n < 1000) begin @(negedge clk); gap_n++; end
      check({tag, "_gap_cycles"}, 32'(gap_n), 32'(GAP));
      check({tag, "_busy_after_gap"}, 32'(busy), 0);
    end else begin
      check({tag, "_drop_ready"}, {30'd0, req_ready, busy}, 32'b10);
      repeat (30) @(negedge clk);
    end
    check({tag, "_byte_count"}, 32'(rx_count - rx0), 32'(exp_len));
    check({tag, "_frame_done_count"}, 32'(fd_count - fd0), has_frame ? 32'd1 : 32'd0);
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 0);
    check({tag, "_addrs_left"}, 32'(addr_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, {req_ready, busy, reg_rd, reg_addr, tx_start, tx_data, frame_done},
          {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
  endtask

  initial begin
    bit hf;
    int rx0, rx1, t;
    for (int i = 0; i < 65536; i++) regfile[i] = 16'(i * 40503 + 4660);
    regfile[0] = 16'h1234;
    regfile[1] = 16'h5678;

    vecs[0] = '{8'h03, 16'h0000, 16'd2,   1,    9};
    vecs[1] = '{8'h03, 16'hFFFF, 16'd2,   3,    9};
    vecs[2] = '{8'h10, 16'hABCD, 16'd125, 2,    8};
    vecs[3] = '{8'h03, 16'h0100, 16'd125, 2,    255};
    vecs[4] = '{8'h03, 16'h0010, 16'd126, 1,    EXC_LEN};
    vecs[5] = '{8'h05, 16'h0000, 16'd1,   1,    EXC_LEN};
    vecs[6] = '{8'h03, 16'h0000, 16'd0,   1,    EXC_LEN};
    vecs[7] = '{8'h10, 16'h0000, 16'd0,   1,    EXC_LEN};
    vecs[8] = '{8'h03, 16'h0020, 16'd1,   2000, 7};
    vecs[9] = '{8'h10, 16'h1234, 16'd1,   4,    8};

    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;

    // Write-multiple echo against the known reference frame
    exp_q.push_back(8'h01); exp_q.push_back(8'h10); exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    exp_q.push_back(8'h10); exp_q.push_back(8'h08);
    do_req(8'h10, 16'h0001, 16'h0002, 5, 1'b1, 8, "echo_ref");

    for (int i = 0; i < 10; i++) begin
      push_model(vecs[i].func, vecs[i].rreg, vecs[i].num, hf);
      do_req(vecs[i].func, vecs[i].rreg, vecs[i].num, vecs[i].dmax, hf, vecs[i].exp_len,
             $sformatf("vec%0d", i));
    end

    // Ignored request while busy, then reset in the middle of the data bytes
    wait_ready();
    uart_dmax = 20;
    push_model(8'h03, 16'h0040, 16'd8, hf);
    rx0 = rx_count;
    @(negedge clk);
    req_valid = 1'b1; req_func = 8'h03; req_reg = 16'h0040; req_num = 16'd8;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (rx_count < rx0 + 5 && t < 5000) begin @(negedge clk); t++; end
    check("midframe_progress", 32'(rx_count >= rx0 + 5), 1);
    req_valid = 1'b1; req_func = 8'h10; req_reg = 16'h0001; req_num = 16'd2;
    check("busy_req_ready_low", {30'd0, req_ready, busy}, 32'b01);
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (rx_count < rx0 + 7 && t < 5000) begin @(negedge clk); t++; end
    check("midframe_progress2", 32'(rx_count >= rx0 + 7), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midframe_reset_values");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx1 = rx_count;
    repeat (40) @(negedge clk);
    check("no_tx_after_reset", 32'(rx_count - rx1), 0);
    check("frame_done_after_reset", 32'(frame_done), 0);
    push_model(8'h03, 16'h0000, 16'd2, hf);
    do_req(8'h03, 16'h0000, 16'd2, 3, hf, 9, "post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
